mac_array_acc: RTL and testbench
================================

MAC_ARRAY_ACC -- requirements
Module: mac_array_acc

Interface
REQ-001 The module SHALL provide parameter N, default 9, the number of lanes (1..64).
REQ-002 The module SHALL provide parameter IW, default 8, the image element width (signed two's complement).
REQ-003 The module SHALL provide parameter WW, default 4, the weight element width (signed two's complement).
REQ-004 The module SHALL provide parameter OW, default 16, the output width (signed).
REQ-005 The module SHALL derive accumulator width ACCW = IW+WW+clog2(N)+8 internally, not as a port parameter.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-007 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 The module SHALL have port in_valid, input, 1 bit: the beat on image/weight is valid.
REQ-009 The module SHALL have port in_first, input, 1 bit: the beat starts a new accumulation; ignored unless in_valid.
REQ-010 The module SHALL have port in_last, input, 1 bit: the beat ends the accumulation; ignored unless in_valid.
REQ-011 The module SHALL have port image, input, N*IW bits: lane 0 in the MSBs and lane N-1 in the LSBs.
REQ-012 The module SHALL have port weight, input, N*WW bits, using the same lane packing as image.
REQ-013 The module SHALL have port out_shift, input, 5 bits: arithmetic right-shift applied to the result, sampled on the last beat.
REQ-014 The module SHALL have port out_valid, output, 1 bit: a one-cycle pulse marking a valid out_data.
REQ-015 The module SHALL have port out_data, output, OW bits: the shifted accumulated dot product, signed.

Function
REQ-016 Stage 1 SHALL register image, weight, in_valid, in_first, in_last and out_shift.
REQ-017 Stage 2 SHALL register the N signed full-width products image_i*weight_i (IW+WW bits each), plus the valid, first, last and shift sidebands.
REQ-018 Stage 3 SHALL register the sign-extended sum of all N products (adder tree, no truncation), plus the sidebands.
REQ-019 Stage 4 SHALL update the accumulator: acc = tree_sum on a first beat, otherwise acc + tree_sum; a non-valid stage-3 slot SHALL leave acc unchanged.
REQ-020 On a stage-3 beat with last=1, out_data SHALL equal sat_or_wrap(new_acc >>> shift), and out_valid SHALL be 1 in the following cycle (total latency 4 cycles, in_last beat to out_valid).
REQ-021 out_valid SHALL be high for exactly one cycle per last beat; out_data SHALL hold its value until the next last beat.
REQ-022 The right shift SHALL be arithmetic, with truncation toward negative infinity (floor); a shift of 0 SHALL pass acc unchanged.
REQ-023 The accumulator SHALL wrap modulo 2^ACCW on internal overflow.
REQ-024 A beat with first=1 and last=1 SHALL produce the single-beat dot product.
REQ-025 A beat with first=1 while an accumulation is open SHALL discard the previous partial sum without producing output.
REQ-026 A valid beat with first=0 and no open accumulation SHALL add onto the current acc (0 after reset).
REQ-027 Idle cycles (in_valid=0) between beats of one accumulation SHALL NOT change the result.
REQ-028 The pipeline SHALL accept a new beat every cycle, with no backpressure.

Reset
REQ-029 When rst=1 at a clock edge, all pipeline valid flags SHALL clear, acc SHALL become 0, out_valid SHALL become 0 and out_data SHALL become 0.
REQ-030 Beats in flight at reset SHALL be dropped and produce no out_valid pulse.
REQ-031 A beat presented in the same cycle as rst=1 SHALL be dropped.

Configuration
REQ-032 With MAC_SAT_EN defined, out_data SHALL saturate to the range [-2^(OW-1), 2^(OW-1)-1].
REQ-033 Without MAC_SAT_EN, out_data SHALL be the low OW bits of the shifted acc (two's complement wrap).

Verification
REQ-034 N=9, IW=8, WW=4, OW=16: all image=1, weight=1, first=last=1, shift=0 -> out_data=9, out_valid exactly 4 cycles later for one cycle.
REQ-035 All image=-128, weight=-8, four beats first..last, shift=0 -> out_data=32767 with MAC_SAT_EN; -28672 without it.
REQ-036 Beat first (all 1x1), then 2 idle cycles, then beat last (all 1x1) -> out_data=18.
REQ-037 Single-beat sum 9 with shift=2 -> out_data=2; sum -9 with shift=2 -> out_data=-3.
REQ-038 Start an accumulation, then a beat with first=1 (sum 5, no last), then a last beat (sum 4) -> out_data=9, with no earlier out_valid.
REQ-039 Assert rst for 1 cycle between first and last beats -> no pulse for in-flight beats, and the last beat alone yields its own sum.

Source files
------------

// File: rtl/mac_array_acc.sv
// ============================================================================
//  mac_array_acc : N-lane signed multiply, adder tree, accumulate, shift, output
//  Optional macro: MAC_SAT_EN (saturate out_data instead of wrapping)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mac_array_acc #(
  parameter int N  = 9,
  parameter int IW = 8,
  parameter int WW = 4,
  parameter int OW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [N*IW-1:0]      image,
  input  logic [N*WW-1:0]      weight,
  input  logic [4:0]           out_shift,
  output logic                 out_valid,
  output logic signed [OW-1:0] out_data
);

  localparam int PW   = IW + WW;
  localparam int ACCW = IW + WW + $clog2(N) + 8;
  localparam int SW   = (ACCW > OW) ? ACCW : OW;

  logic              s1_valid_q, s1_first_q, s1_last_q;
  logic [4:0]        s1_shift_q;
  logic [N*IW-1:0]   s1_img_q;
  logic [N*WW-1:0]   s1_wgt_q;

  logic signed [PW-1:0] prod_d    [N];
  logic signed [PW-1:0] s2_prod_q [N];
  logic              s2_valid_q, s2_first_q, s2_last_q;
  logic [4:0]        s2_shift_q;

  logic signed [ACCW-1:0] sum_d, s3_sum_q;
  logic              s3_valid_q, s3_first_q, s3_last_q;
  logic [4:0]        s3_shift_q;

  logic signed [ACCW-1:0] acc_d, acc_q;
  logic signed [SW-1:0]   shifted_d;
  logic signed [OW-1:0]   result_d, out_data_d, out_data_q;
  logic                   out_valid_q;

  // Lane 0 occupies the most significant slice of each packed bus.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic signed [IW-1:0] a;
    logic signed [WW-1:0] b;
    assign a         = s1_img_q[(N-1-g)*IW +: IW];
    assign b         = s1_wgt_q[(N-1-g)*WW +: WW];
    assign prod_d[g] = PW'(a) * PW'(b);
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) begin
      sum_d = sum_d + ACCW'(s2_prod_q[i]);
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (s3_valid_q) begin
      acc_d = s3_first_q ? s3_sum_q : acc_q + s3_sum_q;
    end
    shifted_d = SW'(acc_d >>> s3_shift_q);
`ifdef MAC_SAT_EN
    begin : g_sat_limits
      localparam logic signed [SW-1:0] C_MAX = SW'($signed({1'b0, {(OW-1){1'b1}}}));
      localparam logic signed [SW-1:0] C_MIN = SW'($signed({1'b1, {(OW-1){1'b0}}}));
      if (shifted_d > C_MAX)      result_d = OW'(C_MAX);
      else if (shifted_d < C_MIN) result_d = OW'(C_MIN);
      else                        result_d = OW'(shifted_d);
    end
`else
    result_d = OW'(shifted_d);
`endif
    out_data_d = out_data_q;
    if (s3_valid_q && s3_last_q) begin
      out_data_d = result_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_shift_q  <= '0;
      s1_img_q    <= '0;
      s1_wgt_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_shift_q  <= '0;
      for (int i = 0; i < N; i++) s2_prod_q[i] <= '0;
      s3_valid_q  <= 1'b0;
      s3_first_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_shift_q  <= '0;
      s3_sum_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= in_valid;
      s1_first_q  <= in_first;
      s1_last_q   <= in_last;
      s1_shift_q  <= out_shift;
      s1_img_q    <= image;
      s1_wgt_q    <= weight;
      s2_valid_q  <= s1_valid_q;
      s2_first_q  <= s1_first_q;
      s2_last_q   <= s1_last_q;
      s2_shift_q  <= s1_shift_q;
      for (int i = 0; i < N; i++) s2_prod_q[i] <= prod_d[i];
      s3_valid_q  <= s2_valid_q;
      s3_first_q  <= s2_first_q;
      s3_last_q   <= s2_last_q;
      s3_shift_q  <= s2_shift_q;
      s3_sum_q    <= sum_d;
      acc_q       <= acc_d;
      out_valid_q <= s3_valid_q & s3_last_q;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_array_acc.sv
// ============================================================================
//  tb_mac_array_acc : scoreboard bench for mac_array_acc against an arithmetic model
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mac_array_acc;

  localparam int N    = 9;
  localparam int IW   = 8;
  localparam int WW   = 4;
  localparam int OW   = 16;
  localparam int ACCW = IW + WW + $clog2(N) + 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [N*IW-1:0]      image = '0;
  logic [N*WW-1:0]      weight = '0;
  logic [4:0]           out_shift = '0;
  logic                 out_valid;
  logic signed [OW-1:0] out_data;

  mac_array_acc #(.N(N), .IW(IW), .WW(WW), .OW(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .image(image), .weight(weight), .out_shift(out_shift),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct { longint dot; bit first; bit last; int sh; int done; } beat_t;
  typedef struct { longint val; int edge_no; } exp_t;
  typedef struct { int idx; longint val; string name; } dir_t;

  beat_t  pend[$];
  exp_t   sb[$];
  dir_t   dir_q[$];
  int     cyc = 0;
  longint acc = 0;
  longint exp_hold = 0;
  bit     model_init = 1'b0;
  bit     finish_req = 1'b0;
  int     pulse_count = 0;
  int     checks = 0;
  int     errors = 0;

  function automatic longint dot_of(input logic [N*IW-1:0] img, input logic [N*WW-1:0] wgt);
    longint s = 0;
    logic signed [IW-1:0] a;
    logic signed [WW-1:0] b;
    for (int i = 0; i < N; i++) begin
      a = img[(N-1-i)*IW +: IW];
      b = wgt[(N-1-i)*WW +: WW];
      s += longint'(a) * longint'(b);
    end
    return s;
  endfunction

  function automatic longint to_signed(input longint x, input int w);
    longint m = longint'(1) << w;
    longint r = x & (m - 1);
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic longint floor_shift(input longint x, input int sh);
    longint p = longint'(1) << sh;
    if (x >= 0) return x / p;
    return -((-x + p - 1) / p);
  endfunction

  function automatic longint out_map(input longint v);
    longint hi = (longint'(1) << (OW - 1)) - 1;
    longint lo = -(longint'(1) << (OW - 1));
`ifdef MAC_SAT_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    if (hi < lo) return 0;
    return to_signed(v, OW);
`endif
  endfunction

  // Reference model: every beat takes effect three edges after it is sampled.
  always @(posedge clk) begin
    beat_t b;
    cyc++;
    if (rst) begin
      pend.delete();
      acc = 0;
      exp_hold = 0;
      model_init = 1'b1;
    end else begin
      while (pend.size() > 0 && pend[0].done == cyc) begin
        b = pend.pop_front();
        acc = to_signed(b.first ? b.dot : acc + b.dot, ACCW);
        if (b.last) begin
          exp_hold = out_map(floor_shift(acc, b.sh));
          sb.push_back('{val: exp_hold, edge_no: cyc});
        end
      end
      if (in_valid) begin
        pend.push_back('{dot: dot_of(image, weight), first: in_first, last: in_last,
                         sh: int'(out_shift), done: cyc + 3});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    dir_t d;
    int   cur;
    if (finish_req) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expected outputs never seen, required 0", sb.size());
      end
      checks++;
      if (dir_q.size() != 0) begin
        errors++;
        $display("FAIL directed_drain: %0d directed results never seen (%s), required 0",
                 dir_q.size(), dir_q[0].name);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end else if (model_init) begin
      if (out_valid === 1'b1) begin
        cur = pulse_count;
        pulse_count++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_pulse: out_valid=1 data=%0d at edge %0d, required no pulse",
                   out_data, cyc);
        end else begin
          e = sb.pop_front();
          if (out_data !== OW'(e.val)) begin
            errors++;
            $display("FAIL out_data: got %0d required %0d", out_data, e.val);
          end
          checks++;
          if (e.edge_no != cyc) begin
            errors++;
            $display("FAIL latency: pulse at edge %0d required edge %0d", cyc, e.edge_no);
          end
        end
        if (dir_q.size() > 0 && dir_q[0].idx == cur) begin
          d = dir_q.pop_front();
          checks++;
          if (out_data !== OW'(d.val)) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", d.name, out_data, d.val);
          end
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_data !== OW'(exp_hold)) begin
          errors++;
          $display("FAIL hold: out_valid=%b out_data=%0d required 0 / %0d",
                   out_valid, out_data, exp_hold);
        end
      end
    end
  end

  function automatic logic [N*IW-1:0] mk_img(input int val, input int lanes);
    logic [N*IW-1:0] r = '0;
    for (int i = 0; i < lanes; i++) r[(N-1-i)*IW +: IW] = IW'(val);
    return r;
  endfunction

  function automatic logic [N*WW-1:0] mk_wgt(input int val);
    logic [N*WW-1:0] r = '0;
    for (int i = 0; i < N; i++) r[(N-1-i)*WW +: WW] = WW'(val);
    return r;
  endfunction

  task automatic beat(input bit f, input bit l, input logic [N*IW-1:0] img,
                      input logic [N*WW-1:0] wgt, input int sh);
    in_valid  = 1'b1;
    in_first  = f;
    in_last   = l;
    image     = img;
    weight    = wgt;
    out_shift = 5'(sh);
    @(negedge clk);
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_dir(input string name, input longint val);
    dir_q.push_back('{idx: pulse_count, val: val, name: name});
  endtask

  initial begin
    logic [N*IW-1:0] ri;
    logic [N*WW-1:0] rw;
    idle(3);
    rst = 1'b0;
    idle(2);

    expect_dir("single_beat_9", 9);
    beat(1, 1, mk_img(1, N), mk_wgt(1), 0);
    idle(6);

`ifdef MAC_SAT_EN
    expect_dir("four_beat_saturate", 32767);
`else
    expect_dir("four_beat_wrap", -28672);
`endif
    beat(1, 0, mk_img(-128, N), mk_wgt(-8), 0);
    beat(0, 0, mk_img(-128, N), mk_wgt(-8), 0);
    beat(0, 0, mk_img(-128, N), mk_wgt(-8), 0);
    beat(0, 1, mk_img(-128, N), mk_wgt(-8), 0);
    idle(6);

    expect_dir("idle_gap_18", 18);
    beat(1, 0, mk_img(1, N), mk_wgt(1), 0);
    idle(2);
    beat(0, 1, mk_img(1, N), mk_wgt(1), 0);
    idle(6);

    expect_dir("shift_pos", 2);
    beat(1, 1, mk_img(1, N), mk_wgt(1), 2);
    idle(6);
    expect_dir("shift_neg_floor", -3);
    beat(1, 1, mk_img(-1, N), mk_wgt(1), 2);
    idle(6);

    expect_dir("restart_discard", 9);
    beat(1, 0, mk_img(3, N), mk_wgt(2), 0);
    beat(1, 0, mk_img(1, 5), mk_wgt(1), 0);
    beat(0, 1, mk_img(1, 4), mk_wgt(1), 0);
    idle(6);

    expect_dir("reset_mid_accum", 4);
    beat(1, 0, mk_img(1, N), mk_wgt(1), 0);
    rst = 1'b1;
    beat(1, 1, mk_img(1, N), mk_wgt(1), 0);
    rst = 1'b0;
    beat(0, 1, mk_img(1, 4), mk_wgt(1), 0);
    idle(6);

    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        for (int i = 0; i < N; i++) begin
          ri[(N-1-i)*IW +: IW] = IW'($urandom);
          rw[(N-1-i)*WW +: WW] = WW'($urandom);
        end
        beat($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, ri, rw,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)));
      end
    end
    idle(10);
    finish_req = 1'b1;
    idle(10);
    $display("FAIL watchdog: summary not reached, required termination");
    $fatal(1);
  end

endmodule

`default_nettype wire
